// File: rtl/wb_cmd_master_if.sv
// Command/response port and Wishbone master-side signals for wb_cmd_master.
// The master modport is the bus initiator's view; slave is the peer's view.
interface wb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;

  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_status,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready,
           wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_status,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic-cycle master: one bus cycle per command,
// with err/ack/rty termination, bounded retries and a per-attempt timeout.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RETRY_GAP      = 4
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  wb_cmd_master_if.master bus
);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(RETRY_GAP - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RTY_EXH = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        adr_reg, adr_next;
  logic [31:0]        dat_reg, dat_next;
  logic [3:0]         sel_reg, sel_next;
  logic               we_reg, we_next;
  logic               cyc_reg, cyc_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [31:0]        rsp_dat_reg, rsp_dat_next;
  logic [1:0]         rsp_status_reg, rsp_status_next;
  logic [RTY_W-1:0]   retry_cnt_reg, retry_cnt_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg      <= IDLE;
      adr_reg        <= '0;
      dat_reg        <= '0;
      sel_reg        <= '0;
      we_reg         <= 1'b0;
      cyc_reg        <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_dat_reg    <= '0;
      rsp_status_reg <= ST_OK;
      retry_cnt_reg  <= '0;
      to_cnt_reg     <= '0;
      gap_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      adr_reg        <= adr_next;
      dat_reg        <= dat_next;
      sel_reg        <= sel_next;
      we_reg         <= we_next;
      cyc_reg        <= cyc_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_dat_reg    <= rsp_dat_next;
      rsp_status_reg <= rsp_status_next;
      retry_cnt_reg  <= retry_cnt_next;
      to_cnt_reg     <= to_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    adr_next        = adr_reg;
    dat_next        = dat_reg;
    sel_next        = sel_reg;
    we_next         = we_reg;
    cyc_next        = cyc_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_dat_next    = rsp_dat_reg;
    rsp_status_next = rsp_status_reg;
    retry_cnt_next  = retry_cnt_reg;
    to_cnt_next     = to_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          adr_next       = bus.cmd_adr;
          dat_next       = bus.cmd_dat;
          sel_next       = bus.cmd_sel;
          we_next        = bus.cmd_we;
          cyc_next       = 1'b1;
          retry_cnt_next = '0;
          to_cnt_next    = '0;
          state_next     = BUS;
        end
      end
      BUS: begin
        // err outranks ack, which outranks rty, when several arrive together
        if (bus.wb_err_i) begin
          cyc_next        = 1'b0;
          rsp_status_next = ST_ERR;
          rsp_dat_next    = '0;
          rsp_valid_next  = 1'b1;
          state_next      = RESP;
        end else if (bus.wb_ack_i) begin
          cyc_next        = 1'b0;
          rsp_status_next = ST_OK;
          rsp_dat_next    = we_reg ? 32'h0 : bus.wb_dat_i;
          rsp_valid_next  = 1'b1;
          state_next      = RESP;
        end else if (bus.wb_rty_i) begin
          cyc_next = 1'b0;
          if (retry_cnt_reg < RTY_LIMIT) begin
            retry_cnt_next = retry_cnt_reg + 1'b1;
            gap_cnt_next   = '0;
            state_next     = GAP;
          end else begin
            rsp_status_next = ST_RTY_EXH;
            rsp_dat_next    = '0;
            rsp_valid_next  = 1'b1;
            state_next      = RESP;
          end
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
          if ((TIMEOUT_CYCLES != 0) && (to_cnt_reg == TO_LAST)) begin
            cyc_next        = 1'b0;
            rsp_status_next = ST_TIMEOUT;
            rsp_dat_next    = '0;
            rsp_valid_next  = 1'b1;
            state_next      = RESP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          cyc_next    = 1'b1;
          to_cnt_next = '0;
          state_next  = BUS;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready  = (state_reg == IDLE) && wb_rst_n;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_dat    = rsp_dat_reg;
  assign bus.rsp_status = rsp_status_reg;
  assign bus.wb_adr_o   = adr_reg;
  assign bus.wb_dat_o   = dat_reg;
  assign bus.wb_sel_o   = sel_reg;
  assign bus.wb_we_o    = we_reg;
  assign bus.wb_cyc_o   = cyc_reg;
  assign bus.wb_stb_o   = cyc_reg;
  assign bus.wb_cti_o   = 3'b000;
  assign bus.wb_bte_o   = 2'b00;
endmodule
